jump_target_encoder: RTL and testbench

Inverse of the CPU's jump-target formation path. The block accepts a jump target address and the PC+4 of the jump slot, and produces the J-format instruction word (`j`/`jal`) whose 26-bit index field regenerates that target. It flags targets that cannot be encoded and buffers results in a 2-entry output queue with valid/ready handshakes. It sits in the instruction-generation/patching path (loader and self-test generator), upstream of instruction memory writes.

---
 rtl/jump_target_encoder.sv | 161 ++++++++++++++++
 tb/tb_jump_target_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jump_target_encoder.sv
// Purpose: encode a jump target and PC+4 into a j/jal instruction word, flag unencodable targets, queue results.
// Latency: an accepted request reaches the output head one cycle later when the queue was empty.
// Backpressure: in_ready_o drops when the 2-entry queue is full and depends only on registered count.
//
// Ports:
//   clk_i, rst_i (async, active-low), flush_i (synchronous queue clear, highest priority)
//   in_valid_i/in_ready_o with pc4_i, target_i, link_i   : request side
//   out_valid_o/out_ready_i with instr_o, err_align_o,
//   err_region_o                                          : result side, zero when empty
//   err_cnt_o                                             : saturating count of accepted erroneous requests
// Build option: define JUMP_ENC_ERR_CNT_EN to build the error counter; otherwise err_cnt_o is tied to zero.

// Two-entry FIFO with synchronous flush; head data reads zero when empty.
// Latency: a push into an empty FIFO is visible at the head the following cycle.
// Backpressure: push_rdy deasserts at count 2 and never looks at pop_rdy.
module jte_fifo #(
   parameter int W = 34
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push, pop;

   assign push_rdy = (count_q != 2'd2);
   assign pop_vld  = (count_q != 2'd0);
   assign push     = push_vld & push_rdy;
   assign pop      = pop_vld & pop_rdy;
   assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         // Flush wins over any simultaneous push or pop.
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

module jump_target_encoder (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] pc4_i,
   input  logic [31:0] target_i,
   input  logic        link_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] instr_o,
   output logic        err_align_o,
   output logic        err_region_o,
   output logic [7:0]  err_cnt_o
);
   typedef struct packed {
      logic [31:0] instr;
      logic        err_align;
      logic        err_region;
   } entry_t;

   entry_t     push_dat;
   entry_t     head_dat;
   logic [5:0] opcode;
   logic       err_align;
   logic       err_region;

   assign opcode     = link_i ? 6'b000011 : 6'b000010;
   assign err_align  = |target_i[1:0];
   // The 26-bit index can only reach the 256 MB region that PC+4 lives in.
   assign err_region = (target_i[31:28] != pc4_i[31:28]);

   always_comb begin
      push_dat            = '0;
      push_dat.instr      = {opcode, target_i[27:2]};
      push_dat.err_align  = err_align;
      push_dat.err_region = err_region;
   end

   jte_fifo #(.W($bits(entry_t))) u_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_i),
      .flush_i  (flush_i),
      .push_vld (in_valid_i),
      .push_rdy (in_ready_o),
      .push_dat (push_dat),
      .pop_vld  (out_valid_o),
      .pop_rdy  (out_ready_i),
      .pop_dat  (head_dat)
   );

   assign instr_o      = head_dat.instr;
   assign err_align_o  = head_dat.err_align;
   assign err_region_o = head_dat.err_region;

`ifdef JUMP_ENC_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts only pushes that actually land; a push dropped by flush is not counted.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (in_valid_i && in_ready_o && !flush_i && (err_align || err_region)
          && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   assign err_cnt_o = 8'h00;
`endif
endmodule

// File: tb/tb_jump_target_encoder.sv
// Purpose: self-checking bench for jump_target_encoder using a queue-level reference model.
// Latency: model updates on each rising edge; DUT outputs are compared on every falling edge.
// Backpressure: exercised by holding out_ready_i low with the queue full.
module tb_jump_target_encoder;
`ifdef JUMP_ENC_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] pc4_i = '0;
   logic [31:0] target_i = '0;
   logic        link_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic        err_align_o;
   logic        err_region_o;
   logic [7:0]  err_cnt_o;

   int vectors = 0;
   int miscompares = 0;

   jump_target_encoder dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .pc4_i        (pc4_i),
      .target_i     (target_i),
      .link_i       (link_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .instr_o      (instr_o),
      .err_align_o  (err_align_o),
      .err_region_o (err_region_o),
      .err_cnt_o    (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: a bounded queue of encoded entries plus an error tally.
   typedef struct {
      logic [31:0] instr;
      logic        a;
      logic        r;
   } ent_t;

   ent_t mq[$];
   int   m_cnt = 0;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mq.delete();
         m_cnt = 0;
      end else begin
         bit   do_push, do_pop;
         ent_t e;
         do_push = in_valid_i && (mq.size() < 2);
         do_pop  = (mq.size() > 0) && out_ready_i;
         if (flush_i) begin
            mq.delete();
         end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               e.instr = {(link_i ? 6'd3 : 6'd2), 26'(target_i >> 2)};
               e.a     = (target_i % 4) != 0;
               e.r     = (target_i >> 28) != (pc4_i >> 28);
               mq.push_back(e);
               if ((e.a || e.r) && CNT_EN && m_cnt < 255) m_cnt++;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_i) begin
      ent_t h;
      h = '{instr: 32'h0, a: 1'b0, r: 1'b0};
      if (mq.size() > 0) h = mq[0];
      chk("in_ready",   {31'b0, in_ready_o},   {31'b0, mq.size() < 2});
      chk("out_valid",  {31'b0, out_valid_o},  {31'b0, mq.size() != 0});
      chk("instr",      instr_o,               h.instr);
      chk("err_align",  {31'b0, err_align_o},  {31'b0, h.a});
      chk("err_region", {31'b0, err_region_o}, {31'b0, h.r});
      chk("err_cnt",    {24'b0, err_cnt_o},    32'(m_cnt));
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] tgt, input logic lnk);
      in_valid_i = v;
      pc4_i      = pc4;
      target_i   = tgt;
      link_i     = lnk;
   endtask

   // One accepted push; returns #1 after the capturing edge.
   task automatic push_one(input logic [31:0] pc4, input logic [31:0] tgt, input logic lnk);
      drive(1'b1, pc4, tgt, lnk);
      step();
      in_valid_i = 1'b0;
   endtask

   task automatic head_is(input string name, input logic [31:0] ins, input logic a, input logic r,
                          input int cnt);
      chk({name, "_instr"}, instr_o, ins);
      chk({name, "_valid"}, {31'b0, out_valid_o}, 32'd1);
      chk({name, "_align"}, {31'b0, err_align_o}, {31'b0, a});
      chk({name, "_region"}, {31'b0, err_region_o}, {31'b0, r});
      chk({name, "_cnt"}, {24'b0, err_cnt_o}, CNT_EN ? 32'(cnt) : 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
      chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_cnt", {24'b0, err_cnt_o}, 32'd0);
      #20 rst_i = 1'b1;
      step();

      // Basic j / jal / errors, consumer always ready
      out_ready_i = 1'b1;
      push_one(32'h0040_0004, 32'h0040_0020, 1'b0);
      head_is("j", 32'h0810_0008, 1'b0, 1'b0, 0);
      push_one(32'h0040_0004, 32'h0040_0020, 1'b1);
      head_is("jal", 32'h0C10_0008, 1'b0, 1'b0, 0);
      push_one(32'h0040_0004, 32'h1000_0000, 1'b0);
      head_is("region", 32'h0800_0000, 1'b0, 1'b1, 1);
      push_one(32'h0040_0004, 32'h0040_0022, 1'b0);
      head_is("align", 32'h0810_0008, 1'b1, 1'b0, 2);
      push_one(32'h0040_0004, 32'h1000_0003, 1'b1);
      head_is("both", 32'h0C00_0000, 1'b1, 1'b1, 3);
      step();
      step();
      chk("drained", {31'b0, out_valid_o}, 32'd0);

      // Backpressure: fill, third request blocked, then drain in order
      out_ready_i = 1'b0;
      push_one(32'h0040_0004, 32'h0040_0100, 1'b0);   // A -> 0x08100040
      push_one(32'h0040_0004, 32'h0040_0200, 1'b1);   // B -> 0x0C100080
      drive(1'b1, 32'h0040_0004, 32'h0040_0300, 1'b0); // C -> 0x081000C0
      chk("full_ready", {31'b0, in_ready_o}, 32'd0);
      step();
      step();
      head_is("full_headA", 32'h0810_0040, 1'b0, 1'b0, 3);
      out_ready_i = 1'b1;
      step();                                          // pop A, C still blocked
      head_is("headB", 32'h0C10_0080, 1'b0, 1'b0, 3);
      step();                                          // pop B and push C together
      in_valid_i = 1'b0;
      head_is("headC", 32'h0810_00C0, 1'b0, 1'b0, 3);
      chk("cnt1_ready", {31'b0, in_ready_o}, 32'd1);
      step();
      chk("empty_after_C", {31'b0, out_valid_o}, 32'd0);

      // Flush at count 2; a same-cycle erroneous push is dropped
      out_ready_i = 1'b0;
      push_one(32'h0040_0004, 32'h2000_0000, 1'b0);
      push_one(32'h0040_0004, 32'h0040_0001, 1'b0);
      drive(1'b1, 32'h0040_0004, 32'h3000_0002, 1'b0);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
      chk("flush_ready", {31'b0, in_ready_o}, 32'd1);
      chk("flush_cnt", {24'b0, err_cnt_o}, CNT_EN ? 32'd5 : 32'd0);

      // Saturation: 300 erroneous pushes with consumer ready
      out_ready_i = 1'b1;
      drive(1'b1, 32'h0040_0004, 32'hF000_0001, 1'b0);
      for (int i = 0; i < 300; i++) step();
      in_valid_i = 1'b0;
      chk("sat_cnt", {24'b0, err_cnt_o}, CNT_EN ? 32'd255 : 32'd0);
      step();

      // Reset mid-stream with a full queue
      out_ready_i = 1'b0;
      push_one(32'h0040_0004, 32'h0040_0400, 1'b0);
      push_one(32'h0040_0004, 32'h0050_0000, 1'b1);
      #1 rst_i = 1'b0;
      #1;
      chk("mrst_ready", {31'b0, in_ready_o}, 32'd1);
      chk("mrst_valid", {31'b0, out_valid_o}, 32'd0);
      chk("mrst_instr", instr_o, 32'd0);
      chk("mrst_flags", {30'b0, err_align_o, err_region_o}, 32'd0);
      chk("mrst_cnt", {24'b0, err_cnt_o}, 32'd0);
      #10 rst_i = 1'b1;
      step();
      out_ready_i = 1'b1;
      push_one(32'h0040_0004, 32'h0040_0020, 1'b0);
      head_is("post_rst", 32'h0810_0008, 1'b0, 1'b0, 0);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
